// File: rtl/wallace_mult_pipe.sv
// Three-stage pipelined Wallace-tree multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned
// per transaction, with a valid/ready handshake and whole-pipeline backpressure.
module wallace_mult_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 sgn,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int W    = int'(WIDTH);
    localparam int PW   = 2 * W;
    localparam int Rows = W + 1;  // partial-product rows plus one constant row

    typedef logic [PW-1:0] row_t;

    logic             v1_q, v2_q, v3_q;
    logic [W-1:0]     a_q, b_q;
    logic             sgn_q;
    row_t             sum_q, carry_q, prod_q;
    row_t             sum_d, carry_d;
    row_t             pp [Rows];
    logic             adv, accept;

    assign adv       = !v3_q || out_ready;
    assign in_ready  = !rst && adv;
    assign accept    = in_valid && in_ready;
    assign prod      = prod_q;
    assign out_valid = v3_q;

    // Baugh-Wooley: in signed mode the cross terms of the MSB row/column are inverted and the
    // correction constants 2^W and 2^(2W-1) go into the extra row.
    always_comb begin
        for (int i = 0; i < Rows; i++) begin
            pp[i] = '0;
        end
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                pp[i][i+j] = (a_q[j] & b_q[i]) ^ (sgn_q & ((i == W - 1) != (j == W - 1)));
            end
        end
        if (sgn_q) begin
            pp[W][W]    = 1'b1;
            pp[W][PW-1] = 1'b1;
        end
    end

    // Wallace reduction: each level compresses rows in groups of three with full adders,
    // passing leftover rows through, until two rows remain.
    always_comb begin : reduce
        row_t work [Rows];
        row_t nxt  [Rows];
        int   n, m, groups;
        work   = pp;
        n      = Rows;
        m      = 0;
        groups = 0;
        for (int lvl = 0; lvl < Rows; lvl++) begin
            for (int r = 0; r < Rows; r++) begin
                nxt[r] = '0;
            end
            if (n > 2) begin
                m      = 0;
                groups = n / 3;
                for (int g = 0; g < Rows / 3; g++) begin
                    if (g < groups) begin
                        nxt[m]   = work[3*g] ^ work[3*g+1] ^ work[3*g+2];
                        nxt[m+1] = ((work[3*g] & work[3*g+1]) |
                                    (work[3*g] & work[3*g+2]) |
                                    (work[3*g+1] & work[3*g+2])) << 1;
                        m        = m + 2;
                    end
                end
                for (int r = 0; r < Rows; r++) begin
                    if (r >= 3 * groups && r < n) begin
                        nxt[m] = work[r];
                        m      = m + 1;
                    end
                end
                n    = m;
                work = nxt;
            end
        end
        sum_d   = work[0];
        carry_d = work[1];
    end

    // Data registers load only behind a valid stage so prod never shows flushed data.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            prod_q <= '0;
        end else if (adv) begin
            v1_q <= accept;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (accept) begin
                a_q   <= a;
                b_q   <= b;
                sgn_q <= sgn;
            end
            if (v1_q) begin
                sum_q   <= sum_d;
                carry_q <= carry_d;
            end
            if (v2_q) begin
                prod_q <= sum_q + carry_q;
            end
        end
    end

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Bench for wallace_mult_pipe: directed scenarios plus randomized streams on WIDTH=8 and an
// exhaustive WIDTH=4 sweep, all checked against a plain-arithmetic reference.
module tb_wallace_mult_pipe;

    logic        clk = 1'b0;
    logic        rst;

    logic [7:0]  a8, b8;
    logic        sgn8, in_valid8, in_ready8, out_valid8, out_ready8;
    logic [15:0] prod8;

    logic [3:0]  a4, b4;
    logic        sgn4, in_valid4, in_ready4, out_valid4, out_ready4;
    logic [7:0]  prod4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wallace_mult_pipe #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .a         (a8),
        .b         (b8),
        .sgn       (sgn8),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .prod      (prod8),
        .out_valid (out_valid8),
        .out_ready (out_ready8)
    );

    wallace_mult_pipe #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .a         (a4),
        .b         (b4),
        .sgn       (sgn4),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .prod      (prod4),
        .out_valid (out_valid4),
        .out_ready (out_ready4)
    );

    // Reference product: interpret operands as w-bit numbers, multiply, keep 2w bits.
    function automatic longint ref_mul(int w, longint x, longint y, bit s);
        longint p, q;
        p = x;
        q = y;
        if (s && p >= (longint'(1) << (w - 1))) p = p - (longint'(1) << w);
        if (s && q >= (longint'(1) << (w - 1))) q = q - (longint'(1) << w);
        return (p * q) & ((longint'(1) << (2 * w)) - 1);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        a8 = 8'd9; b8 = 8'd9; sgn8 = 1'b0; in_valid8 = 1'b1; out_ready8 = 1'b1;
        a4 = 4'd3; b4 = 4'd3; sgn4 = 1'b0; in_valid4 = 1'b1; out_ready4 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        tests++;
        if (out_valid8 !== 1'b0 || prod8 !== 16'h0) begin
            fails++;
            $display("FAIL reset_out8: out_valid=%b prod=%h, expected 0/0000", out_valid8, prod8);
        end
        tests++;
        if (in_ready8 !== 1'b0 || in_ready4 !== 1'b0) begin
            fails++;
            $display("FAIL reset_in_ready: got %b/%b, expected 0/0", in_ready8, in_ready4);
        end
        tests++;
        if (out_valid4 !== 1'b0 || prod4 !== 8'h0) begin
            fails++;
            $display("FAIL reset_out4: out_valid=%b prod=%h, expected 0/00", out_valid4, prod4);
        end
        rst = 1'b0; in_valid8 = 1'b0; in_valid4 = 1'b0; out_ready8 = 1'b0; out_ready4 = 1'b0;
        #1;
        tests++;
        if (in_ready8 !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_in_ready: got %b, expected 1", in_ready8);
        end
    endtask

    task automatic test_unsigned_max();
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; sgn8 = 1'b0; in_valid8 = 1'b1; out_ready8 = 1'b1;
        #1;
        tests++;
        if (in_ready8 !== 1'b1) begin
            fails++;
            $display("FAIL umax_accept: in_ready=%b, expected 1", in_ready8);
        end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            in_valid8 = 1'b0;
            #1;
            tests++;
            if (out_valid8 !== (c == 3)) begin
                fails++;
                $display("FAIL umax_latency c=%0d: out_valid=%b, expected %b", c, out_valid8,
                         c == 3);
            end
            if (c == 3) begin
                tests++;
                if (prod8 !== 16'hFE01) begin
                    fails++;
                    $display("FAIL umax_prod: got %h, expected fe01", prod8);
                end
            end
        end
    endtask

    task automatic test_signed_b2b();
        logic [7:0]  ta [3] = '{8'h80, 8'hFF, 8'h7F};
        logic [7:0]  tb [3] = '{8'h80, 8'h01, 8'h80};
        logic [15:0] te [3] = '{16'h4000, 16'hFFFF, 16'hC080};
        out_ready8 = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            tests++;
            if (out_valid8 !== (c >= 3 && c < 6)) begin
                fails++;
                $display("FAIL signed_valid c=%0d: got %b, expected %b", c, out_valid8,
                         c >= 3 && c < 6);
            end else if (c >= 3 && c < 6 && prod8 !== te[c-3]) begin
                fails++;
                $display("FAIL signed_prod #%0d: got %h, expected %h", c - 3, prod8, te[c-3]);
            end
            in_valid8 = (c < 3);
            if (c < 3) begin
                a8 = ta[c]; b8 = tb[c]; sgn8 = 1'b1;
            end
        end
        in_valid8 = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [7:0] ta [4] = '{8'd3, 8'd7, 8'd2, 8'd0};
        logic [7:0] tb [4] = '{8'd5, 8'd9, 8'd2, 8'd200};
        longint q[$];
        longint e;
        int idx = 0, got = 0, first = -1;
        logic stalled;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            if (out_valid8 && first < 0) first = c;
            stalled    = (first >= 0) && (c < first + 5);
            out_ready8 = !stalled;
            in_valid8  = (idx < 4);
            if (idx < 4) begin
                a8 = ta[idx]; b8 = tb[idx]; sgn8 = 1'b0;
            end
            #1;
            if (stalled) begin
                tests++;
                if (in_ready8 !== 1'b0 || out_valid8 !== 1'b1 || prod8 !== 16'd15) begin
                    fails++;
                    $display("FAIL bp_stall c=%0d: in_ready=%b out_valid=%b prod=%0d, expected 0/1/15",
                             c, in_ready8, out_valid8, prod8);
                end
            end
            if (out_valid8 && out_ready8) begin
                tests++;
                e = (q.size() > 0) ? q.pop_front() : -1;
                if (longint'(prod8) !== e) begin
                    fails++;
                    $display("FAIL bp_order #%0d: got %0d, expected %0d", got, prod8, e);
                end
                got++;
            end
            if (in_valid8 && in_ready8) begin
                q.push_back(ref_mul(8, longint'(a8), longint'(b8), 1'b0));
                idx++;
            end
        end
        tests++;
        if (got != 4) begin
            fails++;
            $display("FAIL bp_count: got %0d results, expected 4", got);
        end
        in_valid8  = 1'b0;
        out_ready8 = 1'b1;
        repeat (5) begin
            @(negedge clk);
            tests++;
            if (out_valid8 !== 1'b0) begin
                fails++;
                $display("FAIL bp_dup: out_valid=%b after drain, expected 0", out_valid8);
            end
        end
    endtask

    task automatic test_reset_midflight();
        out_ready8 = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            a8 = 8'd11 + 8'(c * 6); b8 = 8'd13 + 8'(c * 6); sgn8 = 1'b0; in_valid8 = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1; a8 = 8'd23; b8 = 8'd29;
        #1;
        tests++;
        if (in_ready8 !== 1'b0) begin
            fails++;
            $display("FAIL rst_dominates: in_ready=%b, expected 0", in_ready8);
        end
        @(negedge clk);
        rst = 1'b0; in_valid8 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            tests++;
            if (out_valid8 !== 1'b0 || prod8 !== 16'h0) begin
                fails++;
                $display("FAIL rst_flush c=%0d: out_valid=%b prod=%h, expected 0/0000", c,
                         out_valid8, prod8);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mixed_mode();
        out_ready8 = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            tests++;
            if (out_valid8 !== (c >= 3 && c < 11)) begin
                fails++;
                $display("FAIL mixed_valid c=%0d: got %b, expected %b", c, out_valid8,
                         c >= 3 && c < 11);
            end else if (c >= 3 && c < 11) begin
                if (prod8 !== (((c - 3) % 2 == 0) ? 16'hFE01 : 16'h0001)) begin
                    fails++;
                    $display("FAIL mixed_prod #%0d: got %h, expected %h", c - 3, prod8,
                             ((c - 3) % 2 == 0) ? 16'hFE01 : 16'h0001);
                end
            end
            in_valid8 = (c < 8);
            a8 = 8'hFF; b8 = 8'hFF; sgn8 = c[0];
        end
        in_valid8 = 1'b0;
    endtask

    task automatic test_random8();
        longint q[$];
        longint e;
        int idx = 0, got = 0;
        logic hold;
        logic [15:0] held;
        hold = 1'b0;
        held = '0;
        for (int c = 0; c < 3000 && got < 300; c++) begin
            @(negedge clk);
            if (hold) begin
                tests++;
                if (out_valid8 !== 1'b1 || prod8 !== held) begin
                    fails++;
                    $display("FAIL rand8_hold: out_valid=%b prod=%h, expected 1/%h", out_valid8,
                             prod8, held);
                end
            end
            out_ready8 = ($urandom_range(0, 3) != 0);
            in_valid8  = (idx < 300) && ($urandom_range(0, 3) != 0);
            a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom);
            #1;
            hold = out_valid8 && !out_ready8;
            held = prod8;
            if (out_valid8 && out_ready8) begin
                tests++;
                e = (q.size() > 0) ? q.pop_front() : -1;
                if (longint'(prod8) !== e) begin
                    fails++;
                    $display("FAIL rand8 #%0d: got %h, expected %h", got, prod8, e);
                end
                got++;
            end
            if (in_valid8 && in_ready8) begin
                q.push_back(ref_mul(8, longint'(a8), longint'(b8), sgn8));
                idx++;
            end
        end
        tests++;
        if (got != 300) begin
            fails++;
            $display("FAIL rand8_count: got %0d results, expected 300", got);
        end
        in_valid8 = 1'b0;
    endtask

    task automatic test_exhaustive4();
        longint q[$];
        longint e;
        int idx = 0, got = 0;
        for (int c = 0; c < 5000 && got < 512; c++) begin
            @(negedge clk);
            out_ready4 = ($urandom_range(0, 3) != 0);
            in_valid4  = (idx < 512);
            a4 = 4'(idx >> 4); b4 = 4'(idx); sgn4 = 1'(idx >> 8);
            #1;
            if (out_valid4 && out_ready4) begin
                tests++;
                e = (q.size() > 0) ? q.pop_front() : -1;
                if (longint'(prod4) !== e) begin
                    fails++;
                    $display("FAIL exh4 #%0d: got %h, expected %h", got, prod4, e);
                end
                got++;
            end
            if (in_valid4 && in_ready4) begin
                q.push_back(ref_mul(4, longint'(a4), longint'(b4), sgn4));
                idx++;
            end
        end
        tests++;
        if (got != 512) begin
            fails++;
            $display("FAIL exh4_count: got %0d results, expected 512", got);
        end
        in_valid4  = 1'b0;
        out_ready4 = 1'b1;
        repeat (5) begin
            @(negedge clk);
            tests++;
            if (out_valid4 !== 1'b0) begin
                fails++;
                $display("FAIL exh4_dup: out_valid=%b after drain, expected 0", out_valid4);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_max();
        test_signed_b2b();
        test_backpressure();
        test_reset_midflight();
        test_mixed_mode();
        test_random8();
        test_exhaustive4();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
